// File: rtl/xgriscv_mem_arbiter.sv
// Purpose : share one single-port memory between the fetch (I) and memory-stage (D) ports of xgriscv.
// Latency : grant in IDLE, mem_req from the next cycle, completion on mem_ack (min 2 cycles, 1 IDLE gap).
// Backpr. : requesters hold *_req until *_valid/d_err; *_stall tells the hazard unit to freeze the stage.
//
// Ports
//   clk, rstn            clock; asynchronous reset, active HIGH (rstn = 1 means in reset)
//   i_req/i_addr/i_flush fetch request, address, discard of the outstanding/pending fetch
//   i_rdata/i_valid      fetched word and its 1-cycle completion pulse; i_stall = i_req & ~i_valid
//   d_req/d_we/d_addr/d_wdata/d_be   data request (load/store)
//   d_rdata/d_valid/d_err            load data, completion pulse, timeout pulse; d_stall = d_req & ~d_valid
//   mem_req/mem_we/mem_addr/mem_wdata/mem_be   registered request towards the memory
//   mem_ack/mem_rdata    memory completion pulse and read data (valid with mem_ack)
module xgriscv_mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic              clk,
    input  logic              rstn,
    // fetch port
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_flush,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_valid,
    output logic              i_stall,
    // data port
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [3:0]        d_be,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,
    output logic              d_stall,
    output logic              d_err,
    // memory side
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_be,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_MAX);
    // Abort happens in the BUSY cycle in which the counter would reach TIMEOUT.
    localparam logic [7:0]    TMO_LAST   = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D
    } state_t;

    state_t        state;
    logic [SW-1:0] streak;   // consecutive D grants while I was waiting
    logic [7:0]    tmo;      // BUSY cycles elapsed without mem_ack
    logic          drop;     // current fetch was flushed; swallow its completion

    logic grant_d;
    logic grant_i;
    logic tmo_hit;

    // Data wins unless it has already beaten a waiting fetch STARVE_MAX times in a row.
    assign grant_d = (state == IDLE) && d_req && (!i_req || (streak < STREAK_MAX));
    assign grant_i = (state == IDLE) && !grant_d && i_req && !i_flush;
    assign tmo_hit = !mem_ack && (tmo == TMO_LAST);

    // Completion is combinational on mem_ack; read data is a straight pass-through.
    // A flush arriving in the ack cycle itself also kills the fetch result.
    assign i_valid = (state == BUSY_I) && mem_ack && !drop && !i_flush;
    assign d_valid = (state == BUSY_D) && mem_ack;
    assign d_err   = (state == BUSY_D) && tmo_hit;
    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;

    // Stalls are forced low while reset is applied, independent of the requesters.
    assign i_stall = !rstn && i_req && !i_valid;
    assign d_stall = !rstn && d_req && !d_valid;

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= 4'h0;
            streak    <= '0;
            tmo       <= 8'h00;
            drop      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // mem_ack seen here belongs to no access (e.g. after an abort) and is ignored.
                    if (grant_d) begin
                        state     <= BUSY_D;
                        mem_req   <= 1'b1;
                        mem_we    <= d_we;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        mem_be    <= d_be;
                        tmo       <= 8'h00;
                        if (!i_req) begin
                            streak <= '0;
                        end else if (streak != STREAK_MAX) begin
                            streak <= streak + SW'(1);
                        end
                    end else if (grant_i) begin
                        state     <= BUSY_I;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= i_addr;
                        mem_wdata <= '0;
                        mem_be    <= 4'hF;
                        tmo       <= 8'h00;
                        streak    <= '0;
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (mem_ack || tmo_hit) begin
                        // Done or aborted; an aborted fetch is retried because i_req stays high.
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        drop    <= 1'b0;
                        tmo     <= 8'h00;
                    end else begin
                        tmo <= tmo + 8'h01;
                        if ((state == BUSY_I) && i_flush) begin
                            drop <= 1'b1;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                    drop    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xgriscv_mem_arbiter.sv
// Bench for xgriscv_mem_arbiter: directed scenarios with literal expectations, then random traffic,
// all continuously compared against a transaction-level reference of the arbiter.
module tb_xgriscv_mem_arbiter;

    localparam int SMAX = 4;
    localparam int TMO  = 255;

    logic        clk = 1'b0;
    logic        rstn;
    logic        i_req, i_flush;
    logic [31:0] i_addr, i_rdata;
    logic        i_valid, i_stall;
    logic        d_req, d_we;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [3:0]  d_be;
    logic        d_valid, d_stall, d_err;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    always #5 clk = ~clk;

    xgriscv_mem_arbiter #(
        .ADDR_W(32), .DATA_W(32), .STARVE_MAX(SMAX), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rstn(rstn),
        .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush),
        .i_rdata(i_rdata), .i_valid(i_valid), .i_stall(i_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_rdata(d_rdata), .d_valid(d_valid), .d_stall(d_stall), .d_err(d_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- memory responder ----------------
    int ack_lat   = 1;      // BUSY cycles before ack (0 = ack in first BUSY cycle)
    bit ack_rand  = 1'b0;
    bit ack_en    = 1'b1;
    int spur_cnt  = 0;
    int spur_done = 0;
    int r_cnt     = 0;
    int r_lat     = 0;

    initial begin
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
            if (spur_cnt != spur_done) begin
                mem_ack = 1'b1;
                spur_done++;
            end else if (!mem_req) begin
                r_cnt = 0;
            end else begin
                if (r_cnt == 0) r_lat = ack_rand ? int'($urandom_range(0, 3)) : ack_lat;
                if (ack_en && r_cnt == r_lat) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem_addr ^ 32'hC0DE_0000;
                end
                r_cnt++;
            end
        end
    end

    // ---------------- reference model + per-cycle compare ----------------
    // owner: 0 = nobody, 1 = fetch, 2 = data
    int          m_owner = 0;
    int          m_wait  = 0;
    int          m_run   = 0;
    bit          m_disc  = 1'b0;
    logic        m_we    = 1'b0;
    logic [31:0] m_addr  = 32'h0;
    logic [31:0] m_wdata = 32'h0;
    logic [3:0]  m_be    = 4'h0;
    bit          e_iv, e_dv, e_de;

    always @(negedge clk) begin
        if (rstn === 1'b1) begin
            m_owner = 0; m_wait = 0; m_run = 0; m_disc = 1'b0;
            m_we = 1'b0; m_addr = 32'h0; m_wdata = 32'h0; m_be = 4'h0;
            chk("rst_mem_req", 32'(mem_req), 32'd0);
            chk("rst_mem_addr", mem_addr, 32'd0);
            chk("rst_i_stall", 32'(i_stall), 32'd0);
            chk("rst_d_stall", 32'(d_stall), 32'd0);
            chk("rst_i_valid", 32'(i_valid), 32'd0);
            chk("rst_d_valid", 32'(d_valid), 32'd0);
            chk("rst_d_err", 32'(d_err), 32'd0);
        end else if (rstn === 1'b0) begin
            e_iv = (m_owner == 1) && mem_ack && !m_disc && !i_flush;
            e_dv = (m_owner == 2) && mem_ack;
            e_de = (m_owner == 2) && !mem_ack && (m_wait == TMO - 1);
            chk("i_valid", 32'(i_valid), 32'(e_iv));
            chk("d_valid", 32'(d_valid), 32'(e_dv));
            chk("d_err", 32'(d_err), 32'(e_de));
            chk("i_stall", 32'(i_stall), 32'(i_req && !e_iv));
            chk("d_stall", 32'(d_stall), 32'(d_req && !e_dv));
            chk("mem_req", 32'(mem_req), 32'(m_owner != 0));
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_we", 32'(mem_we), 32'(m_we));
            chk("mem_wdata", mem_wdata, m_wdata);
            chk("mem_be", 32'(mem_be), 32'(m_be));
            if (e_iv) chk("i_rdata", i_rdata, mem_rdata);
            if (e_dv) chk("d_rdata", d_rdata, mem_rdata);
            // advance one cycle
            if (m_owner != 0) begin
                if (mem_ack || m_wait == TMO - 1) begin
                    m_owner = 0;
                    m_disc  = 1'b0;
                end else begin
                    m_wait++;
                    if (m_owner == 1 && i_flush) m_disc = 1'b1;
                end
            end else if (d_req && (!i_req || m_run < SMAX)) begin
                m_owner = 2; m_wait = 0;
                m_we = d_we; m_addr = d_addr; m_wdata = d_wdata; m_be = d_be;
                m_run = i_req ? ((m_run < SMAX) ? m_run + 1 : SMAX) : 0;
            end else if (i_req && !i_flush) begin
                m_owner = 1; m_wait = 0;
                m_we = 1'b0; m_addr = i_addr; m_wdata = 32'h0; m_be = 4'hF;
                m_run = 0;
            end
        end
    end

    // ---------------- directed + random stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    bit          iv, dv, de, got, i_done, d_done, f_seen;
    int          first_done, n, rise, vcyc, vcnt, dcount, d_before_i, busy, ecyc, ecount, acks, nI, nD;
    logic [31:0] f_addr, f_wdata, rd, va, ma;
    logic        f_we;

    task automatic serve(input int budget);
        int k;
        k = 0;
        i_done = 1'b0; d_done = 1'b0; first_done = 0; f_seen = 1'b0;
        while ((i_req || d_req) && k < budget) begin
            @(negedge clk);
            if (mem_req && !f_seen) begin
                f_seen = 1'b1; f_addr = mem_addr; f_we = mem_we; f_wdata = mem_wdata;
            end
            iv = i_valid; dv = d_valid;
            step();
            if (iv) begin i_req = 1'b0; i_done = 1'b1; if (first_done == 0) first_done = 1; end
            if (dv) begin d_req = 1'b0; d_done = 1'b1; if (first_done == 0) first_done = 2; end
            k++;
        end
        if (i_req || d_req) begin
            checks++; errors++;
            $display("FAIL serve_budget requests still pending after %0d cycles", budget);
            i_req = 1'b0; d_req = 1'b0;
        end
    endtask

    initial begin
        rstn = 1'b1;
        i_req = 1'b0; i_flush = 1'b0; i_addr = 32'h0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_be = 4'hF;

        // 1: reset with both requesting, then both served
        i_req = 1'b1; i_addr = 32'h10; d_req = 1'b1; d_addr = 32'h20;
        repeat (3) step();
        @(negedge clk);
        chk("t1_rst_mem_req", 32'(mem_req), 32'd0);
        chk("t1_rst_i_stall", 32'(i_stall), 32'd0);
        chk("t1_rst_d_stall", 32'(d_stall), 32'd0);
        step();
        rstn = 1'b0;
        serve(100);
        chk("t1_i_served", 32'(i_done), 32'd1);
        chk("t1_d_served", 32'(d_done), 32'd1);
        chk("t1_d_first", 32'(first_done), 32'd2);
        step();

        // 2: single fetch, ack 3 cycles after mem_req
        ack_lat = 3;
        i_req = 1'b1; i_addr = 32'h78;
        rise = -1; vcyc = -1; vcnt = 0; rd = 32'h0; ma = 32'h0;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (mem_req && rise < 0) begin rise = c; ma = mem_addr; end
            iv = i_valid;
            if (iv) begin vcnt++; vcyc = c; rd = i_rdata; end
            step();
            if (iv) i_req = 1'b0;
        end
        chk("t2_mem_addr", ma, 32'h78);
        chk("t2_valid_count", 32'(vcnt), 32'd1);
        chk("t2_ack_distance", 32'(vcyc - rise), 32'd3);
        chk("t2_i_rdata", rd, 32'hC0DE_0078);

        // 3: contention, store wins
        ack_lat = 1;
        i_req = 1'b1; i_addr = 32'h200;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; d_be = 4'hF;
        serve(100);
        chk("t3_d_first", 32'(first_done), 32'd2);
        chk("t3_first_addr", f_addr, 32'h100);
        chk("t3_first_we", 32'(f_we), 32'd1);
        chk("t3_first_wdata", f_wdata, 32'hDEAD_BEEF);
        chk("t3_i_served", 32'(i_done), 32'd1);
        step();

        // 4: starvation limit with 6 back-to-back loads
        i_req = 1'b1; i_addr = 32'h300;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1000;
        dcount = 0; d_before_i = -1; n = 0;
        while ((i_req || d_req) && n < 200) begin
            @(negedge clk);
            iv = i_valid; dv = d_valid;
            step();
            if (dv) begin
                dcount++;
                d_addr = d_addr + 32'd4;
                if (dcount == 6) d_req = 1'b0;
            end
            if (iv) begin d_before_i = dcount; i_req = 1'b0; end
            n++;
        end
        chk("t4_d_before_i", 32'(d_before_i), 32'd4);
        chk("t4_d_total", 32'(dcount), 32'd6);
        step();

        // 5: flush during second BUSY_I cycle, then new fetch
        ack_lat = 3;
        i_req = 1'b1; i_addr = 32'h400;
        n = 0;
        do begin
            @(negedge clk);
            got = mem_req;
            step();
            n++;
        end while (!got && n < 20);
        i_flush = 1'b1;
        step();
        i_flush = 1'b0; i_addr = 32'h500;
        vcnt = 0; va = 32'h0; rd = 32'h0; acks = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (mem_req && mem_ack && mem_addr == 32'h400) acks++;
            iv = i_valid;
            if (iv) begin vcnt++; va = mem_addr; rd = i_rdata; end
            step();
            if (iv) i_req = 1'b0;
        end
        chk("t5_flushed_ack_at_mem", 32'(acks), 32'd1);
        chk("t5_valid_count", 32'(vcnt), 32'd1);
        chk("t5_valid_addr", va, 32'h500);
        chk("t5_i_rdata", rd, 32'hC0DE_0500);

        // 6: data timeout, then a late ack is ignored
        ack_en = 1'b0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h600;
        busy = 0; ecyc = -1; ecount = 0; n = 0;
        while (d_req && n < 400) begin
            @(negedge clk);
            if (mem_req) busy++;
            de = d_err;
            if (de) begin ecount++; ecyc = busy; end
            step();
            if (de) d_req = 1'b0;
            n++;
        end
        if (d_req) begin
            checks++; errors++;
            $display("FAIL t6_no_err d_err not seen within %0d cycles", n);
            d_req = 1'b0;
        end
        chk("t6_err_cycle", 32'(ecyc), 32'd255);
        chk("t6_err_count", 32'(ecount), 32'd1);
        @(negedge clk);
        chk("t6_mem_req_after", 32'(mem_req), 32'd0);
        step();
        spur_cnt++;
        vcnt = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (d_valid || i_valid || d_err) vcnt++;
            step();
        end
        chk("t6_late_ack_ignored", 32'(vcnt), 32'd0);
        ack_en = 1'b1;

        // 7: reset in the middle of an access
        ack_lat = 3;
        i_req = 1'b1; i_addr = 32'h700;
        n = 0;
        do begin
            @(negedge clk);
            got = mem_req;
            step();
            n++;
        end while (!got && n < 20);
        rstn = 1'b1;
        #1;
        chk("t7_async_mem_req", 32'(mem_req), 32'd0);
        i_req = 1'b0;
        step();
        step();
        rstn = 1'b0;
        step();

        // random traffic
        ack_rand = 1'b1;
        nI = 0; nD = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            iv = i_valid; dv = d_valid; de = d_err;
            step();
            if (iv) nI++;
            if (dv) nD++;
            if (i_req && (iv || i_flush)) i_req = 1'b0;
            i_flush = 1'b0;
            if (!i_req) begin
                if ($urandom_range(0, 2) == 0) begin
                    i_req  = 1'b1;
                    i_addr = $urandom & 32'hFFFF_FFFC;
                end
            end else if ($urandom_range(0, 15) == 0) begin
                i_flush = 1'b1;
            end
            if (d_req && (dv || de)) d_req = 1'b0;
            if (!d_req && $urandom_range(0, 2) == 0) begin
                d_req   = 1'b1;
                d_we    = 1'($urandom_range(0, 1));
                d_addr  = $urandom & 32'hFFFF_FFFC;
                d_wdata = $urandom;
                d_be    = 4'($urandom_range(0, 15));
            end
        end
        chk("rand_i_progress", 32'(nI > 10), 32'd1);
        chk("rand_d_progress", 32'(nD > 10), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
